// File: rtl/iob_eth_mii_tx_sink.sv
// MII transmit sink: strips preamble/SFD, rebuilds bytes, checks the Ethernet FCS and
// queues frame bytes in a ready/valid FIFO with per-frame status.
module iob_eth_mii_tx_sink #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MIN_PRE    = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       mii_txd_i,
  input  logic             mii_tx_en_i,
  input  logic             mii_tx_er_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  output logic             byte_last_o,
  input  logic             byte_ready_i,
  output logic             frame_done_o,
  output logic             frame_ok_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             err_crc_o,
  output logic             err_sfd_o,
  output logic             err_align_o,
  output logic             err_txer_o,
  output logic             err_ovf_o,
  output logic [LEN_W-1:0] frame_cnt_o
);

  localparam int unsigned  PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt   = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [31:0]  CrcPoly    = 32'hEDB88320;
  localparam logic [31:0]  CrcResidue = 32'hDEBB20E3;

  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic             odd_q, odd_d;
  logic [3:0]       low_q, low_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             stg_valid_q, stg_valid_d;
  logic [7:0]       stg_byte_q, stg_byte_d;
  logic             acc_sfd_q, acc_sfd_d;
  logic             acc_txer_q, acc_txer_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic [LEN_W-1:0] fcnt_q, fcnt_d;
  logic             e_crc_q, e_crc_d;
  logic             e_sfd_q, e_sfd_d;
  logic             e_align_q, e_align_d;
  logic             e_txer_q, e_txer_d;
  logic             e_ovf_q, e_ovf_d;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [8:0]       head;

  logic             push, push_last, push_ok, pop, full, ovf_now;
  logic             frame_end, align_err, crc_bad;
  logic [7:0]       nib_byte;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~mii_tx_en_i;
    pre_cnt_d   = pre_cnt_q;
    odd_d       = odd_q;
    low_d       = low_q;
    crc_d       = crc_q;
    len_d       = len_q;
    stg_valid_d = stg_valid_q;
    stg_byte_d  = stg_byte_q;
    acc_sfd_d   = acc_sfd_q;
    acc_txer_d  = acc_txer_q;
    acc_ovf_d   = acc_ovf_q;
    push        = 1'b0;
    push_last   = 1'b0;
    frame_end   = 1'b0;
    align_err   = 1'b0;
    nib_byte    = {mii_txd_i, low_q};

    unique case (state_q)
      StIdle: begin
        // armed_q keeps a frame already in flight at reset release from being accepted
        if (mii_tx_en_i && armed_q) begin
          state_d     = mii_tx_er_i ? StDrop : StPre;
          pre_cnt_d   = (mii_txd_i == 4'h5) ? 8'd1 : 8'd0;
          odd_d       = 1'b0;
          crc_d       = 32'hFFFF_FFFF;
          len_d       = '0;
          stg_valid_d = 1'b0;
          acc_sfd_d   = 1'b0;
          acc_txer_d  = mii_tx_er_i;
          acc_ovf_d   = 1'b0;
        end
      end
      StPre: begin
        if (!mii_tx_en_i) begin
          frame_end = 1'b1;
          state_d   = StIdle;
        end else if (mii_tx_er_i) begin
          acc_txer_d = 1'b1;
          state_d    = StDrop;
        end else if (mii_txd_i == 4'h5) begin
          if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (mii_txd_i == 4'hD && 32'(pre_cnt_q) >= MIN_PRE) begin
          state_d = StData;
        end else begin
          acc_sfd_d = 1'b1;
          state_d   = StDrop;
        end
      end
      StData: begin
        if (!mii_tx_en_i) begin
          push      = stg_valid_q;
          push_last = 1'b1;
          align_err = odd_q;
          frame_end = 1'b1;
          state_d   = StIdle;
        end else if (mii_tx_er_i) begin
          push        = stg_valid_q;
          push_last   = 1'b1;
          stg_valid_d = 1'b0;
          acc_txer_d  = 1'b1;
          state_d     = StDrop;
        end else if (!odd_q) begin
          low_d = mii_txd_i;
          odd_d = 1'b1;
        end else begin
          odd_d = 1'b0;
          crc_d = crc_byte(crc_q, nib_byte);
          if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
          // one-byte stage lets the final byte be tagged last when tx_en drops
          push        = stg_valid_q;
          stg_byte_d  = nib_byte;
          stg_valid_d = 1'b1;
        end
      end
      StDrop: begin
        if (!mii_tx_en_i) begin
          frame_end = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    pop     = byte_ready_i & (count_q != '0);
    full    = (count_q == FullCnt);
    push_ok = push & (~full | pop);
    ovf_now = push & full & ~pop;
    if (ovf_now) acc_ovf_d = 1'b1;

    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - (PtrW+1)'(1);
    end

    done_d    = frame_end;
    ok_d      = ok_q;
    flen_d    = flen_q;
    fcnt_d    = fcnt_q;
    e_crc_d   = e_crc_q;
    e_sfd_d   = e_sfd_q;
    e_align_d = e_align_q;
    e_txer_d  = e_txer_q;
    e_ovf_d   = e_ovf_q;
    crc_bad   = (len_q != '0) && (crc_q != CrcResidue);
    if (frame_end) begin
      flen_d    = len_q;
      e_crc_d   = crc_bad;
      e_sfd_d   = acc_sfd_q | (state_q == StPre);
      e_align_d = align_err;
      e_txer_d  = acc_txer_q;
      e_ovf_d   = acc_ovf_q | ovf_now;
      ok_d      = !(e_crc_d | e_sfd_d | e_align_d | e_txer_d | e_ovf_d) &&
                  (len_q >= LEN_W'(4));
      fcnt_d    = fcnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      pre_cnt_q   <= '0;
      odd_q       <= 1'b0;
      low_q       <= '0;
      crc_q       <= 32'hFFFF_FFFF;
      len_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_byte_q  <= '0;
      acc_sfd_q   <= 1'b0;
      acc_txer_q  <= 1'b0;
      acc_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      flen_q      <= '0;
      fcnt_q      <= '0;
      e_crc_q     <= 1'b0;
      e_sfd_q     <= 1'b0;
      e_align_q   <= 1'b0;
      e_txer_q    <= 1'b0;
      e_ovf_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      pre_cnt_q   <= pre_cnt_d;
      odd_q       <= odd_d;
      low_q       <= low_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      stg_valid_q <= stg_valid_d;
      stg_byte_q  <= stg_byte_d;
      acc_sfd_q   <= acc_sfd_d;
      acc_txer_q  <= acc_txer_d;
      acc_ovf_q   <= acc_ovf_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      flen_q      <= flen_d;
      fcnt_q      <= fcnt_d;
      e_crc_q     <= e_crc_d;
      e_sfd_q     <= e_sfd_d;
      e_align_q   <= e_align_d;
      e_txer_q    <= e_txer_d;
      e_ovf_q     <= e_ovf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= {push_last, stg_byte_q};
  end

  assign head         = mem_q[rptr_q];
  assign byte_valid_o = (count_q != '0);
  assign byte_o       = byte_valid_o ? head[7:0] : 8'h00;
  assign byte_last_o  = byte_valid_o & head[8];
  assign frame_done_o = done_q;
  assign frame_ok_o   = ok_q;
  assign frame_len_o  = flen_q;
  assign err_crc_o    = e_crc_q;
  assign err_sfd_o    = e_sfd_q;
  assign err_align_o  = e_align_q;
  assign err_txer_o   = e_txer_q;
  assign err_ovf_o    = e_ovf_q;
  assign frame_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_iob_eth_mii_tx_sink.sv
// Bench for iob_eth_mii_tx_sink: table of frame scenarios plus overflow/drain and
// mid-frame reset sequences, with bytes collected from the FIFO and compared.
module tb_iob_eth_mii_tx_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  txd;
  logic        tx_en, tx_er, ready;
  logic [7:0]  byte_o;
  logic        byte_valid, byte_last, frame_done, frame_ok;
  logic [15:0] frame_len, frame_cnt;
  logic        err_crc, err_sfd, err_align, err_txer, err_ovf;

  always #5 clk = ~clk;

  iob_eth_mii_tx_sink #(.FIFO_DEPTH(16), .LEN_W(16), .MIN_PRE(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mii_txd_i(txd), .mii_tx_en_i(tx_en),
    .mii_tx_er_i(tx_er), .byte_o(byte_o), .byte_valid_o(byte_valid),
    .byte_last_o(byte_last), .byte_ready_i(ready), .frame_done_o(frame_done),
    .frame_ok_o(frame_ok), .frame_len_o(frame_len), .err_crc_o(err_crc),
    .err_sfd_o(err_sfd), .err_align_o(err_align), .err_txer_o(err_txer),
    .err_ovf_o(err_ovf), .frame_cnt_o(frame_cnt)
  );

  typedef struct {
    int npre; logic [3:0] sfd; int npay; int flip; int er; bit odd;
    int nbytes; int len; bit ok; bit crc; bit sfde; bit align; bit txer;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          exp_cnt = 0;
  logic [8:0]  rx_q[$];
  logic [7:0]  fbytes [0:127];
  int          fb_n;

  always @(negedge clk) begin
    if (rst_n && byte_valid && ready) rx_q.push_back({byte_last, byte_o});
    if (frame_done) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Bit-serial LFSR form of the reflected CRC-32
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        f;
    r = c;
    for (int k = 0; k < 8; k++) begin
      f = r[0] ^ b[k];
      r = {1'b0, r[31:1]};
      if (f) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_frame(input int npay, input int seed);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < npay; i++) begin
      fbytes[i] = 8'(i * 37 + seed * 11 + 5);
      c = crc_bits(c, fbytes[i]);
    end
    c = ~c;
    fbytes[npay]     = c[7:0];
    fbytes[npay + 1] = c[15:8];
    fbytes[npay + 2] = c[23:16];
    fbytes[npay + 3] = c[31:24];
    fb_n = npay + 4;
  endtask

  task automatic drive(input logic [3:0] d, input logic en, input logic er);
    txd = d; tx_en = en; tx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int npre, input logic [3:0] sfd, input int flip_nib,
                            input int er_nib, input bit odd, input int rst_nib);
    logic [3:0] n;
    for (int i = 0; i < npre; i++) drive(4'h5, 1'b1, 1'b0);
    drive(sfd, 1'b1, 1'b0);
    for (int i = 0; i < 2 * fb_n; i++) begin
      n = (i % 2 == 0) ? fbytes[i / 2][3:0] : fbytes[i / 2][7:4];
      if (i == flip_nib) n = n ^ 4'h1;
      if (i == rst_nib) rst_n = 1'b0;
      drive(n, 1'b1, (i == er_nib));
      rst_n = 1'b1;
    end
    if (odd) drive(4'hA, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) drive(4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string nm, input int nbytes, input int nlast_exp,
                             input int len, input bit ok, input bit crc, input bit sfde,
                             input bit align, input bit txer, input bit ovf,
                             input int flip_nib);
    int         nlast, nbad;
    logic [7:0] e;
    nlast = 0;
    nbad  = 0;
    chk({nm, "_nbytes"}, rx_q.size(), nbytes);
    foreach (rx_q[j]) begin
      if (rx_q[j][8]) nlast++;
      e = fbytes[j];
      if (flip_nib >= 0 && j == flip_nib / 2) e = e ^ ((flip_nib % 2 != 0) ? 8'h10 : 8'h01);
      if (rx_q[j][7:0] != e) nbad++;
    end
    chk({nm, "_nlast"}, nlast, nlast_exp);
    if (nlast_exp > 0)
      chk({nm, "_last_pos"}, (rx_q.size() > 0) ? rx_q[rx_q.size() - 1][8] : 1'b0, 1);
    chk({nm, "_data_bad"}, nbad, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_len"}, frame_len, len);
    chk({nm, "_ok"}, frame_ok, ok);
    chk({nm, "_err_crc"}, err_crc, crc);
    chk({nm, "_err_sfd"}, err_sfd, sfde);
    chk({nm, "_err_align"}, err_align, align);
    chk({nm, "_err_txer"}, err_txer, txer);
    chk({nm, "_err_ovf"}, err_ovf, ovf);
    chk({nm, "_frame_cnt"}, frame_cnt, exp_cnt);
  endtask

  initial begin
    vec_t v[8];
    v[0] = '{7, 4'hD, 60, -1, -1, 1'b0, 64, 64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1] = '{7, 4'hD, 60, 10, -1, 1'b0, 64, 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[2] = '{2, 4'h3, 60, -1, -1, 1'b0,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[3] = '{7, 4'hD, 60, -1, 40, 1'b0, 20, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[4] = '{7, 4'hD, 60, -1, -1, 1'b1, 64, 64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v[5] = '{2, 4'hD, 60, -1, -1, 1'b0, 64, 64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[6] = '{1, 4'hD, 60, -1, -1, 1'b0,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v[7] = '{7, 4'hD,  1, -1, -1, 1'b0,  5,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; txd = 4'h0; tx_en = 1'b0; tx_er = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", byte_valid, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_errs", {err_crc, err_sfd, err_align, err_txer, err_ovf}, 0);
    rst_n = 1'b1;
    drive(4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rx_q.delete();
      done_cnt = 0;
      build_frame(v[i].npay, i);
      send_frame(v[i].npre, v[i].sfd, v[i].flip, v[i].er, v[i].odd, -1);
      exp_cnt++;
      check_frame($sformatf("v%0d", i), v[i].nbytes, (v[i].nbytes > 0) ? 1 : 0, v[i].len,
                  v[i].ok, v[i].crc, v[i].sfde, v[i].align, v[i].txer, 1'b0, v[i].flip);
    end

    // Overflow: consumer stalled for a whole 64-byte frame, then drains
    rx_q.delete();
    done_cnt = 0;
    ready = 1'b0;
    build_frame(60, 20);
    send_frame(7, 4'hD, -1, -1, 1'b0, -1);
    exp_cnt++;
    check_frame("ovf", 0, 0, 64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    chk("ovf_held_valid", byte_valid, 1);
    chk("ovf_head_byte", byte_o, fbytes[0]);
    ready = 1'b1;
    for (int i = 0; i < 40; i++) drive(4'h0, 1'b0, 1'b0);
    check_frame("drain", 16, 0, 64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    chk("drain_empty", byte_valid, 0);

    // Reset pulse in the middle of a frame, FIFO partly full
    rx_q.delete();
    done_cnt = 0;
    ready = 1'b0;
    build_frame(60, 21);
    send_frame(7, 4'hD, -1, -1, 1'b0, 60);
    chk("mrst_done_cnt", done_cnt, 0);
    chk("mrst_valid", byte_valid, 0);
    chk("mrst_cnt", frame_cnt, 0);
    chk("mrst_len", frame_len, 0);
    chk("mrst_errs", {err_crc, err_sfd, err_align, err_txer, err_ovf}, 0);
    exp_cnt = 0;
    rx_q.delete();
    ready = 1'b1;
    build_frame(60, 22);
    send_frame(7, 4'hD, -1, -1, 1'b0, -1);
    exp_cnt++;
    check_frame("post_rst", 64, 1, 64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
